// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: receiver states, baud-rate constants
// and the ASCII digit range used by the console traffic.
package uart_pkg;

  localparam int CLK_HZ               = 12_000_000;
  localparam int BAUD                 = 9600;
  localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

  localparam logic [7:0] ASCII_0 = 8'd48;
  localparam logic [7:0] ASCII_9 = 8'd57;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rxState_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input line.
// Both flops reset to 1 so an idle line never looks like a start edge.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling from a single system clock, one-cycle
// valid / framing-error pulses and a held copy of the last good byte.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(2);

  rxState_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frameErr_q;
  logic             busy_q;
  logic             rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(rx),
    .sync_o (rx_s)
  );

  assign shift_d = {rx_s, shift_q[7:1]};

  // WAIT_HIGH first lets the synchronizer flush its reset value of 1, so a line
  // held low across reset or after a broken frame is never taken as idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_HIGH;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      busy_q     <= (state_q == START) || (state_q == DATA) || (state_q == STOP);
      unique case (state_q)
        WAIT_HIGH: begin
          if (cnt_q != FLUSH_CNT) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (rx_s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              bitIdx_q <= '0;
              state_q  <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = frameErr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: a fast-baud instance for most traffic
// and a default-baud instance for the exact 9600-baud latency.
module tb_uart_rx_8n1;
  import uart_pkg::*;

  localparam int CPB     = 100;
  localparam int HALF    = CPB / 2;
  localparam int LAT     = 2 + HALF + 9 * CPB;
  localparam int CPB_DEF = DEFAULT_CLKS_PER_BIT;
  localparam int LAT_DEF = 2 + CPB_DEF / 2 + 9 * CPB_DEF;
  localparam int NVEC    = 6;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
    int         at;
  } pulse_t;

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       stopBit;
    int         lowAfter;
    bit         expErr;
    logic [7:0] expData;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       rxDef = 1'b1;
  logic [7:0] rxData, rxDataDef;
  logic       rxValid, rxFrameErr, rxBusy;
  logic       rxValidDef, rxFrameErrDef, rxBusyDef;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         t0;
  logic [7:0] lastGood = 8'h00;
  bit         prevPulse = 1'b0;
  pulse_t     expQ[$];
  pulse_t     obsQ[$];
  pulse_t     obsDefQ[$];
  pulse_t     mp, mpDef, pd;
  vec_t       vecTable[NVEC];
  vec_t       v;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rxData),
    .rx_valid    (rxValid),
    .rx_frame_err(rxFrameErr),
    .rx_busy     (rxBusy)
  );

  uart_rx_8n1 dutDef (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rxDef),
    .rx_data     (rxDataDef),
    .rx_valid    (rxValidDef),
    .rx_frame_err(rxFrameErrDef),
    .rx_busy     (rxBusyDef)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse with its cycle index; pulses must be isolated and exclusive.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevPulse = 1'b0;
    end else begin
      if (rxValid || rxFrameErr) begin
        vectors++;
        if ((rxValid && rxFrameErr) || prevPulse) begin
          miscompares++;
          $display("[TB] FAIL pulse isolation: valid=%0b err=%0b prev=%0b, required one isolated pulse",
                   rxValid, rxFrameErr, prevPulse);
        end
        mp.isErr = rxFrameErr;
        mp.data  = rxData;
        mp.at    = cyc;
        obsQ.push_back(mp);
      end
      prevPulse = rxValid || rxFrameErr;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (rxValidDef || rxFrameErrDef)) begin
      mpDef.isErr = rxFrameErrDef;
      mpDef.data  = rxDataDef;
      mpDef.at    = cyc;
      obsDefQ.push_back(mpDef);
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic driveLine(input bit sel, input logic val);
    if (sel) rxDef = val;
    else     rx    = val;
  endtask

  task automatic sendFrame(input bit sel, input logic [7:0] b, input int period, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      driveLine(sel, bits[i]);
      repeat (period) @(negedge clk);
    end
  endtask

  // The reference: a frame starting at T0 reports at T0+LAT; good stop updates
  // the held byte, bad stop reports the previously held byte.
  task automatic applyStimulus(input vec_t vec);
    pulse_t e;
    e.isErr = vec.expErr;
    e.data  = vec.expData;
    e.at    = cyc + 1 + LAT;
    expQ.push_back(e);
    if (!vec.expErr) lastGood = vec.expData;
    sendFrame(1'b0, vec.data, vec.period, vec.stopBit);
    if (vec.lowAfter > 0) repeat (vec.lowAfter) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    pulse_t e, o;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (obsQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s missing pulse: got none, expected err=%0b data %02h at cycle %0d",
                 tag, e.isErr, e.data, e.at);
      end else begin
        o = obsQ.pop_front();
        checkVal({tag, " kind"}, 32'(o.isErr), 32'(e.isErr));
        checkVal({tag, " data"}, 32'(o.data), 32'(e.data));
        checkVal({tag, " cycle"}, o.at, e.at);
      end
    end
    while (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s extra pulse: got err=%0b data %02h at cycle %0d, expected none",
               tag, o.isErr, o.data, o.at);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    miscompares++;
    $display("[TB] FAIL watchdog: got cycle %0d, expected completion before it", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecTable[0] = '{8'h41, CPB,     1'b1, 0,       1'b0, 8'h41};
    vecTable[1] = '{8'h35, CPB,     1'b1, 0,       1'b0, 8'h35};
    vecTable[2] = '{8'hA5, CPB,     1'b0, 2 * CPB, 1'b1, 8'h35};
    vecTable[3] = '{8'h30, CPB,     1'b1, 0,       1'b0, 8'h30};
    vecTable[4] = '{8'h55, CPB - 3, 1'b1, 0,       1'b0, 8'h55};
    vecTable[5] = '{8'hAA, CPB + 3, 1'b1, 0,       1'b0, 8'hAA};

    repeat (3) @(negedge clk);
    checkVal("reset rx_data", rxData, 0);
    checkVal("reset rx_valid", rxValid, 0);
    checkVal("reset rx_frame_err", rxFrameErr, 0);
    checkVal("reset rx_busy", rxBusy, 0);
    checkVal("reset rx_data def", rxDataDef, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] 0x35 at default baud");
    t0 = cyc + 1;
    fork
      sendFrame(1'b1, 8'h35, CPB_DEF, 1'b1);
      begin
        waitCyc(t0 + 2);
        checkVal("def busy T0+2", rxBusyDef, 0);
        waitCyc(t0 + 3);
        checkVal("def busy T0+3", rxBusyDef, 1);
        waitCyc(t0 + LAT_DEF - 1);
        checkVal("def busy before stop", rxBusyDef, 1);
      end
    join
    repeat (10) @(negedge clk);
    checkVal("def pulse count", obsDefQ.size(), 1);
    if (obsDefQ.size() > 0) begin
      pd = obsDefQ.pop_front();
      checkVal("def kind", 32'(pd.isErr), 0);
      checkVal("def data", 32'(pd.data), 32'h35);
      checkVal("def cycle", pd.at, t0 + LAT_DEF);
    end
    checkVal("def busy after stop", rxBusyDef, 0);
    checkVal("def held data", rxDataDef, 8'h35);

    $display("[TB] start glitch");
    t0 = cyc + 1;
    rx = 1'b0;
    waitCyc(t0 + 30);
    rx = 1'b1;
    waitCyc(t0 + 40);
    checkVal("glitch busy", rxBusy, 1);
    waitCyc(t0 + HALF + 10);
    checkVal("glitch busy released", rxBusy, 0);
    repeat (CPB) @(negedge clk);
    checkVal("glitch pulses", obsQ.size(), 0);

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecTable[i]);
      repeat (2 * CPB) @(negedge clk);
      checkOutput($sformatf("vec%0d", i));
    end

    $display("[TB] back-to-back digits");
    for (int d = ASCII_0; d <= ASCII_9; d++) begin
      v = '{8'(d), CPB, 1'b1, 0, 1'b0, 8'(d)};
      applyStimulus(v);
    end
    repeat (2 * CPB) @(negedge clk);
    checkOutput("b2b");

    $display("[TB] reset during data bit 3");
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checkVal("midreset rx_data", rxData, 0);
    checkVal("midreset rx_valid", rxValid, 0);
    checkVal("midreset rx_frame_err", rxFrameErr, 0);
    checkVal("midreset rx_busy", rxBusy, 0);
    rst_n = 1'b1;
    lastGood = 8'h00;
    repeat (CPB - 30 + 4 * CPB) @(negedge clk);
    checkVal("held-low busy", rxBusy, 0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkVal("held-low pulses", obsQ.size(), 0);
    checkVal("held-low rx_data", rxData, 0);
    v = '{ASCII_9, CPB, 1'b1, 0, 1'b0, ASCII_9};
    applyStimulus(v);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("post-reset");

    $display("[TB] random frames");
    for (int i = 0; i < 12; i++) begin
      v.data     = 8'($urandom_range(0, 255));
      v.period   = $urandom_range(CPB - 3, CPB + 3);
      v.stopBit  = ($urandom_range(0, 4) != 0);
      v.lowAfter = 0;
      v.expErr   = !v.stopBit;
      v.expData  = v.stopBit ? v.data : lastGood;
      applyStimulus(v);
      if (!v.stopBit || ($urandom_range(0, 1) == 1))
        repeat ($urandom_range(CPB, 2 * CPB)) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
    checkOutput("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
